bp_be_branch_feedback: RTL and testbench

Backend-side source of front-end branch feedback. Takes one resolved control-transfer or exception per cycle from the execute pipe and compares the fetched-next PC with the architecturally correct one. Mispredictions and exceptions become a one-cycle redirect. Correct predictions become training "attaboy" messages, held in a small queue until the front end accepts them. It sits between the BE execute/commit stage and the FE PC generator's redirect and attaboy ports.

---
 rtl/bp_be_pkg.sv | 29 ++
 rtl/bp_be_attaboy_queue.sv | 82 ++++++++
 rtl/bp_be_branch_feedback.sv | 152 +++++++++++++++
 tb/tb_bp_be_branch_feedback.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_be_pkg.sv
// Shared types for the backend branch-feedback path: control state, front-end
// branch metadata layout, and the attaboy queue entry declaration macro.
`define DECLARE_BP_BE_ATTABOY_ENTRY_S(vaddr_width_mp, metadata_width_mp) \
    typedef struct packed {                                              \
        logic [vaddr_width_mp-1:0]    pc;                                \
        logic                         taken;                             \
        logic                         ntaken;                            \
        logic [metadata_width_mp-1:0] metadata;                          \
    } bp_be_attaboy_entry_s

package bp_be_pkg;

    typedef enum logic [0:0] {
        e_run   = 1'b0,
        e_redir = 1'b1
    } bp_be_fb_state_e;

    typedef struct packed {
        logic       is_br;
        logic       is_jal;
        logic       is_jalr;
        logic [7:0] bht_idx;
        logic [7:0] ghist;
    } bp_fe_branch_metadata_fwd_s;

    localparam int vaddr_width_gp               = 39;
    localparam int branch_metadata_fwd_width_gp = $bits(bp_fe_branch_metadata_fwd_s);

endpackage

// File: rtl/bp_be_attaboy_queue.sv
// Register-based 1r1w FIFO with valid/yumi output, synchronous clear and
// wrap-bit full/empty detection; depth need not be a power of two.
module bp_be_attaboy_queue #(
    parameter int els_p   = 2,
    parameter int width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               clear_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               full_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    localparam int idx_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam logic [idx_w_lp-1:0] last_idx_lp = idx_w_lp'(els_p - 1);

    logic [width_p-1:0]  mem_r [els_p];
    logic [idx_w_lp-1:0] rd_idx_r, wr_idx_r;
    logic                rd_wrap_r, wr_wrap_r;
    logic                empty_s, full_s, deq_s, enq_s;

    function automatic logic [idx_w_lp-1:0] next_idx(input logic [idx_w_lp-1:0] idx);
        if (idx == last_idx_lp) begin
            return '0;
        end else begin
            return idx + idx_w_lp'(1);
        end
    endfunction

    // Occupancy flags and the accepted enqueue/dequeue strobes.
    always_comb begin
        empty_s = (rd_idx_r == wr_idx_r) && (rd_wrap_r == wr_wrap_r);
        full_s  = (rd_idx_r == wr_idx_r) && (rd_wrap_r != wr_wrap_r);
        deq_s   = yumi_i & ~empty_s;
        // A full queue still accepts when its head leaves the same cycle.
        enq_s   = v_i & (~full_s | deq_s);
    end

    // Read/write pointers with wrap bits.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rd_idx_r  <= '0;
            wr_idx_r  <= '0;
            rd_wrap_r <= 1'b0;
            wr_wrap_r <= 1'b0;
        end else if (clear_i) begin
            rd_idx_r  <= '0;
            wr_idx_r  <= '0;
            rd_wrap_r <= 1'b0;
            wr_wrap_r <= 1'b0;
        end else begin
            if (deq_s) begin
                rd_idx_r  <= next_idx(rd_idx_r);
                rd_wrap_r <= rd_wrap_r ^ (rd_idx_r == last_idx_lp);
            end
            if (enq_s) begin
                wr_idx_r  <= next_idx(wr_idx_r);
                wr_wrap_r <= wr_wrap_r ^ (wr_idx_r == last_idx_lp);
            end
        end
    end

    // Entry storage.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < els_p; i++) begin
                mem_r[i] <= '0;
            end
        end else if (enq_s && !clear_i) begin
            mem_r[wr_idx_r] <= data_i;
        end
    end

    assign full_o = full_s;
    assign v_o    = ~empty_s;
    assign data_o = mem_r[rd_idx_r];

endmodule

// File: rtl/bp_be_branch_feedback.sv
// Turns resolved branches/exceptions into one-cycle FE redirects, and correct
// predictions into queued attaboy training messages.
module bp_be_branch_feedback
    import bp_be_pkg::*;
#(
    parameter int vaddr_width_p               = vaddr_width_gp,
    parameter int branch_metadata_fwd_width_p = branch_metadata_fwd_width_gp,
    parameter int attaboy_els_p               = 2
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,
    input  logic                                   br_v_i,
    input  logic [vaddr_width_p-1:0]               br_pc_i,
    input  logic [vaddr_width_p-1:0]               br_npc_pred_i,
    input  logic [vaddr_width_p-1:0]               br_npc_i,
    input  logic                                   br_taken_i,
    input  logic                                   br_nonbr_i,
    input  logic [branch_metadata_fwd_width_p-1:0] br_metadata_fwd_i,
    input  logic                                   xcpt_v_i,
    input  logic [vaddr_width_p-1:0]               xcpt_pc_i,
    output logic                                   redirect_v_o,
    output logic [vaddr_width_p-1:0]               redirect_pc_o,
    output logic                                   redirect_br_v_o,
    output logic                                   redirect_br_taken_o,
    output logic                                   redirect_br_ntaken_o,
    output logic                                   redirect_br_nonbr_o,
    output logic [branch_metadata_fwd_width_p-1:0] redirect_br_metadata_fwd_o,
    output logic                                   attaboy_v_o,
    output logic [vaddr_width_p-1:0]               attaboy_pc_o,
    output logic                                   attaboy_taken_o,
    output logic                                   attaboy_ntaken_o,
    output logic [branch_metadata_fwd_width_p-1:0] attaboy_br_metadata_fwd_o,
    input  logic                                   attaboy_yumi_i,
    output logic [15:0]                            drop_count_o
);

    `DECLARE_BP_BE_ATTABOY_ENTRY_S(vaddr_width_p, branch_metadata_fwd_width_p);

    bp_fe_branch_metadata_fwd_s md_s;
    bp_be_attaboy_entry_s       enq_entry_s, head_s;
    bp_be_fb_state_e            state_r, state_n;
    logic mispredict_s, redir_s, correct_s, taken_s, ntaken_s;
    logic q_full_s, q_v_s, q_yumi_s, drop_s;
    logic [15:0] drop_count_r;
    logic unused_s;

    assign md_s     = br_metadata_fwd_i[$bits(bp_fe_branch_metadata_fwd_s)-1:0];
    assign unused_s = ^br_pc_i ^ (^md_s);

    // Event classification, exception taking priority over any branch.
    always_comb begin
        mispredict_s = br_v_i & ((br_npc_pred_i != br_npc_i) | br_nonbr_i);
        redir_s      = xcpt_v_i | mispredict_s;
        correct_s    = br_v_i & ~xcpt_v_i & ~mispredict_s;
        taken_s      = br_taken_i & ~br_nonbr_i;
        ntaken_s     = md_s.is_br & ~br_taken_i & ~br_nonbr_i;
        enq_entry_s  = '{pc: br_npc_i, taken: taken_s, ntaken: ntaken_s,
                         metadata: br_metadata_fwd_i};
    end

    // Next control state.
    always_comb begin
        state_n = e_run;
        case (state_r)
            e_run:   state_n = redir_s ? e_redir : e_run;
            e_redir: state_n = redir_s ? e_redir : e_run;
            default: state_n = e_run;
        endcase
    end

    // Control state register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= e_run;
        end else begin
            state_r <= state_n;
        end
    end

    // Redirect payload, zeroed in cycles without a redirect.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            redirect_pc_o              <= '0;
            redirect_br_v_o            <= 1'b0;
            redirect_br_taken_o        <= 1'b0;
            redirect_br_ntaken_o       <= 1'b0;
            redirect_br_nonbr_o        <= 1'b0;
            redirect_br_metadata_fwd_o <= '0;
        end else if (xcpt_v_i) begin
            redirect_pc_o              <= xcpt_pc_i;
            redirect_br_v_o            <= 1'b0;
            redirect_br_taken_o        <= 1'b0;
            redirect_br_ntaken_o       <= 1'b0;
            redirect_br_nonbr_o        <= 1'b0;
            redirect_br_metadata_fwd_o <= '0;
        end else if (mispredict_s) begin
            redirect_pc_o              <= br_npc_i;
            redirect_br_v_o            <= 1'b1;
            redirect_br_taken_o        <= taken_s;
            redirect_br_ntaken_o       <= ntaken_s;
            redirect_br_nonbr_o        <= br_nonbr_i;
            redirect_br_metadata_fwd_o <= br_metadata_fwd_i;
        end else begin
            redirect_pc_o              <= '0;
            redirect_br_v_o            <= 1'b0;
            redirect_br_taken_o        <= 1'b0;
            redirect_br_ntaken_o       <= 1'b0;
            redirect_br_nonbr_o        <= 1'b0;
            redirect_br_metadata_fwd_o <= '0;
        end
    end

    assign redirect_v_o = (state_r == e_redir);

    // Queued attaboys carry stale ghist once a redirect happens, so flush them.
    bp_be_attaboy_queue #(
        .els_p   (attaboy_els_p),
        .width_p ($bits(bp_be_attaboy_entry_s))
    ) queue (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .clear_i   (redir_s),
        .v_i       (correct_s),
        .data_i    (enq_entry_s),
        .full_o    (q_full_s),
        .v_o       (q_v_s),
        .data_o    (head_s),
        .yumi_i    (q_yumi_s)
    );

    assign attaboy_v_o               = q_v_s & ~redirect_v_o;
    assign q_yumi_s                  = attaboy_yumi_i & attaboy_v_o;
    assign attaboy_pc_o              = attaboy_v_o ? head_s.pc : '0;
    assign attaboy_taken_o           = attaboy_v_o & head_s.taken;
    assign attaboy_ntaken_o          = attaboy_v_o & head_s.ntaken;
    assign attaboy_br_metadata_fwd_o = attaboy_v_o ? head_s.metadata : '0;
    assign drop_s                    = correct_s & q_full_s & ~q_yumi_s;

    // Saturating count of attaboys lost to a full queue.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            drop_count_r <= 16'h0000;
        end else if (drop_s && (drop_count_r != 16'hFFFF)) begin
            drop_count_r <= drop_count_r + 16'h0001;
        end else begin
            drop_count_r <= drop_count_r;
        end
    end

    assign drop_count_o = drop_count_r;

endmodule

// File: tb/tb_bp_be_branch_feedback.sv
// Scoreboard bench for bp_be_branch_feedback: stimulus pushes expected
// redirects/attaboys, a negedge monitor pops and compares them.
module tb_bp_be_branch_feedback;
    import bp_be_pkg::*;

    localparam int VW  = vaddr_width_gp;
    localparam int MW  = branch_metadata_fwd_width_gp;
    localparam int ELS = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          br_v = 1'b0, br_taken = 1'b0, br_nonbr = 1'b0, xcpt_v = 1'b0, yumi = 1'b0;
    logic [VW-1:0] br_pc = '0, br_npc_pred = '0, br_npc = '0, xcpt_pc = '0;
    logic [MW-1:0] br_md = '0;
    logic          redirect_v, redirect_br_v, redirect_taken, redirect_ntaken, redirect_nonbr;
    logic [VW-1:0] redirect_pc, attaboy_pc;
    logic [MW-1:0] redirect_md, attaboy_md;
    logic          attaboy_v, attaboy_taken, attaboy_ntaken;
    logic [15:0]   drop_count;

    typedef struct {
        logic [VW-1:0] pc;
        logic br_v, taken, ntaken, nonbr;
        logic [MW-1:0] md;
    } redir_t;
    typedef struct {
        logic [VW-1:0] pc;
        logic taken, ntaken;
        logic [MW-1:0] md;
    } ab_t;

    redir_t exp_redir[$];
    ab_t    exp_ab[$];
    int     total = 0;
    int     bad = 0;
    int     exp_drops = 0;

    bp_be_branch_feedback #(.attaboy_els_p(ELS)) dut (
        .clk_i                      (clk),
        .reset_n_i                  (rst_n),
        .br_v_i                     (br_v),
        .br_pc_i                    (br_pc),
        .br_npc_pred_i              (br_npc_pred),
        .br_npc_i                   (br_npc),
        .br_taken_i                 (br_taken),
        .br_nonbr_i                 (br_nonbr),
        .br_metadata_fwd_i          (br_md),
        .xcpt_v_i                   (xcpt_v),
        .xcpt_pc_i                  (xcpt_pc),
        .redirect_v_o               (redirect_v),
        .redirect_pc_o              (redirect_pc),
        .redirect_br_v_o            (redirect_br_v),
        .redirect_br_taken_o        (redirect_taken),
        .redirect_br_ntaken_o       (redirect_ntaken),
        .redirect_br_nonbr_o        (redirect_nonbr),
        .redirect_br_metadata_fwd_o (redirect_md),
        .attaboy_v_o                (attaboy_v),
        .attaboy_pc_o               (attaboy_pc),
        .attaboy_taken_o            (attaboy_taken),
        .attaboy_ntaken_o           (attaboy_ntaken),
        .attaboy_br_metadata_fwd_o  (attaboy_md),
        .attaboy_yumi_i             (yumi),
        .drop_count_o               (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [MW-1:0] mk_md(input logic is_br, input logic is_jal,
                                            input logic is_jalr, input logic [7:0] idx);
        bp_fe_branch_metadata_fwd_s m;
        m = '{is_br: is_br, is_jal: is_jal, is_jalr: is_jalr, bht_idx: idx, ghist: 8'h5A};
        return m;
    endfunction

    // Monitor: compare every presented redirect and every consumed attaboy.
    always @(negedge clk) begin
        if (rst_n) begin
            if (redirect_v) begin
                check("ab_masked_in_redirect", {63'd0, attaboy_v}, 64'd0);
                if (exp_redir.size() == 0) begin
                    check("unexpected_redirect", {63'd0, redirect_v}, 64'd0);
                end else begin
                    redir_t e;
                    e = exp_redir.pop_front();
                    check("redirect_pc", 64'(redirect_pc), 64'(e.pc));
                    check("redirect_flags",
                          {60'd0, redirect_br_v, redirect_taken, redirect_ntaken, redirect_nonbr},
                          {60'd0, e.br_v, e.taken, e.ntaken, e.nonbr});
                    check("redirect_md", 64'(redirect_md), 64'(e.md));
                end
            end
            if (attaboy_v && yumi) begin
                if (exp_ab.size() == 0) begin
                    check("unexpected_attaboy", {63'd0, attaboy_v}, 64'd0);
                end else begin
                    ab_t a;
                    a = exp_ab.pop_front();
                    check("attaboy_pc", 64'(attaboy_pc), 64'(a.pc));
                    check("attaboy_flags", {62'd0, attaboy_taken, attaboy_ntaken},
                          {62'd0, a.taken, a.ntaken});
                    check("attaboy_md", 64'(attaboy_md), 64'(a.md));
                end
            end
        end
    end

    // Drive one event at posedge+1, model it, and return at the next posedge+1.
    task automatic send(input logic bv, input logic [VW-1:0] pc, input logic [VW-1:0] pred,
                        input logic [VW-1:0] npc, input logic tk, input logic nb,
                        input logic [MW-1:0] md, input logic xv, input logic [VW-1:0] xpc,
                        input logic yu);
        bp_fe_branch_metadata_fwd_s m;
        logic mis;
        m = md;
        br_v = bv; br_pc = pc; br_npc_pred = pred; br_npc = npc; br_taken = tk;
        br_nonbr = nb; br_md = md; xcpt_v = xv; xcpt_pc = xpc; yumi = yu;
        mis = bv & ((pred != npc) | nb);
        if (xv) begin
            exp_redir.push_back('{pc: xpc, br_v: 1'b0, taken: 1'b0, ntaken: 1'b0, nonbr: 1'b0, md: '0});
            exp_ab.delete();
        end else if (mis) begin
            exp_redir.push_back('{pc: npc, br_v: 1'b1, taken: tk & ~nb,
                                  ntaken: m.is_br & ~tk & ~nb, nonbr: nb, md: md});
            exp_ab.delete();
        end else if (bv) begin
            if (exp_ab.size() < ELS || yu) begin
                exp_ab.push_back('{pc: npc, taken: tk & ~nb, ntaken: m.is_br & ~tk & ~nb, md: md});
            end else begin
                exp_drops++;
            end
        end
        @(posedge clk); #1;
        br_v = 1'b0; xcpt_v = 1'b0; br_nonbr = 1'b0; yumi = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk); #1;
    endtask

    task automatic pop();
        check("pop_head_valid", {63'd0, attaboy_v}, 64'd1);
        yumi = 1'b1;
        @(posedge clk); #1;
        yumi = 1'b0;
    endtask

    task automatic do_reset(input string name);
        rst_n = 1'b0;
        br_v = 1'b0; xcpt_v = 1'b0; yumi = 1'b0;
        #1;
        check(name, {63'd0, |{redirect_v, redirect_pc, redirect_br_v, redirect_taken,
                              redirect_ntaken, redirect_nonbr, redirect_md, attaboy_v,
                              attaboy_pc, attaboy_taken, attaboy_ntaken, attaboy_md,
                              drop_count}}, 64'd0);
        exp_redir.delete();
        exp_ab.delete();
        exp_drops = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [MW-1:0] beq, jalr, alu;
        beq  = mk_md(1'b1, 1'b0, 1'b0, 8'h11);
        jalr = mk_md(1'b0, 1'b0, 1'b1, 8'h22);
        alu  = mk_md(1'b0, 1'b0, 1'b0, 8'h33);

        #2;
        do_reset("reset_outputs");

        // Correct taken beq: attaboy one cycle later, consumed by yumi.
        send(1'b1, 39'h1000, 39'h1040, 39'h1040, 1'b1, 1'b0, beq, 1'b0, 39'h0, 1'b0);
        check("attaboy_latency", {63'd0, attaboy_v}, 64'd1);
        pop();
        check("attaboy_empty_after_yumi", {63'd0, attaboy_v}, 64'd0);

        // Mispredicted not-taken beq: one-cycle redirect.
        send(1'b1, 39'h1000, 39'h1040, 39'h1004, 1'b0, 1'b0, beq, 1'b0, 39'h0, 1'b0);
        check("redirect_latency", {63'd0, redirect_v}, 64'd1);
        idle();
        check("redirect_one_cycle", {63'd0, redirect_v}, 64'd0);
        check("queue_unchanged", {63'd0, attaboy_v}, 64'd0);

        // Fill and drop, then FIFO drain.
        send(1'b1, 39'h1ffc, 39'h2000, 39'h2000, 1'b1, 1'b0, beq, 1'b0, 39'h0, 1'b0);
        send(1'b1, 39'h2000, 39'h2004, 39'h2004, 1'b0, 1'b0, beq, 1'b0, 39'h0, 1'b0);
        send(1'b1, 39'h2004, 39'h2008, 39'h2008, 1'b1, 1'b0, beq, 1'b0, 39'h0, 1'b0);
        check("drop_count", 64'(drop_count), 64'(exp_drops));
        pop();
        pop();
        check("drained", {63'd0, attaboy_v}, 64'd0);

        // Enqueue onto a full queue succeeds with a same-cycle yumi.
        send(1'b1, 39'h3000, 39'h3010, 39'h3010, 1'b1, 1'b0, beq, 1'b0, 39'h0, 1'b0);
        send(1'b1, 39'h3010, 39'h3020, 39'h3020, 1'b1, 1'b0, alu, 1'b0, 39'h0, 1'b0);
        send(1'b1, 39'h3020, 39'h3030, 39'h3030, 1'b0, 1'b0, beq, 1'b0, 39'h0, 1'b1);
        check("no_drop_with_yumi", 64'(drop_count), 64'(exp_drops));

        // jalr mispredict flushes the two queued attaboys.
        send(1'b1, 39'h3030, 39'h4000, 39'h4100, 1'b1, 1'b0, jalr, 1'b0, 39'h0, 1'b0);
        check("flush_masks_attaboy", {63'd0, attaboy_v}, 64'd0);
        idle();
        check("flush_empties_queue", {63'd0, attaboy_v}, 64'd0);

        // Exception beats a same-cycle mispredict; back-to-back redirect follows.
        send(1'b1, 39'h5000, 39'h5040, 39'h5004, 1'b0, 1'b0, beq, 1'b1, 39'h8000, 1'b0);
        send(1'b1, 39'h6000, 39'h6004, 39'h6004, 1'b0, 1'b1, alu, 1'b0, 39'h0, 1'b0);
        check("back_to_back_redirect", {63'd0, redirect_v}, 64'd1);
        idle();
        check("redirect_ends", {63'd0, redirect_v}, 64'd0);

        // Async reset with a queued entry and a nonzero drop count.
        send(1'b1, 39'h7000, 39'h7004, 39'h7004, 1'b0, 1'b0, beq, 1'b0, 39'h0, 1'b0);
        send(1'b1, 39'h7004, 39'h7008, 39'h7008, 1'b0, 1'b0, beq, 1'b0, 39'h0, 1'b0);
        send(1'b1, 39'h7008, 39'h700c, 39'h700c, 1'b0, 1'b0, beq, 1'b0, 39'h0, 1'b0);
        check("drop_before_reset", 64'(drop_count), 64'(exp_drops));
        #1;
        do_reset("reset_drops_queue");
        idle();
        check("empty_after_reset", {63'd0, attaboy_v}, 64'd0);

        // Async reset while a redirect is presented.
        send(1'b1, 39'h9000, 39'h9040, 39'h9004, 1'b0, 1'b0, beq, 1'b0, 39'h0, 1'b0);
        check("redirect_before_reset", {63'd0, redirect_v}, 64'd1);
        #5;
        do_reset("reset_drops_redirect");
        idle();

        check("redirect_leftover", 64'(exp_redir.size()), 64'd0);
        check("attaboy_leftover", 64'(exp_ab.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
